// File: rtl/motor_pwm_if.sv
// Steering-in / PWM-out bundle between the PID controller side and the motor PWM stage.
// The master drives enable/steer; the slave (motor_pwm) returns PWM, duties and status.
interface motor_pwm_if;
    logic        enable;
    logic [10:0] steer;
    logic        pwm_l;
    logic        pwm_r;
    logic [10:0] duty_l;
    logic [10:0] duty_r;
    logic        period_start;
    logic        running;

    modport master (
        output enable, steer,
        input  pwm_l, pwm_r, duty_l, duty_r, period_start, running
    );

    modport slave (
        input  enable, steer,
        output pwm_l, pwm_r, duty_l, duty_r, period_start, running
    );
endinterface

// File: rtl/motor_pwm.sv
// Differential-drive PWM stage: steer word -> slew-limited left/right duties, updated at period boundaries.
// PWM is one cycle behind the counter; MOTOR_PWM_SLEW_EN enables per-period slew limiting of the duties.
module motor_pwm #(
    parameter int PERIOD     = 1000,
    parameter int BASE_SPEED = 600,
    parameter int SLEW       = 50
) (
    input  logic        clk,
    input  logic        rst,
    motor_pwm_if.slave  bus
);
    localparam int CNT_W = $clog2(PERIOD);
`ifdef MOTOR_PWM_SLEW_EN
    localparam int MAX_STEP = SLEW;
`else
    // No slew limiting: any step spanning the full duty range is allowed.
    localparam int MAX_STEP = (SLEW > 1000) ? SLEW : 1000;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [10:0]        duty_l_q, duty_l_d;
    logic [10:0]        duty_r_q, duty_r_d;
    logic               pwm_l_q, pwm_r_q;
    logic               period_start_q;
    logic               boundary;
    logic signed [12:0] steer_c;
    logic signed [12:0] off;
    logic signed [12:0] tgt_l;
    logic signed [12:0] tgt_r;

    function automatic logic signed [12:0] clamp_duty(input logic signed [12:0] v);
        logic signed [12:0] r;
        r = v;
        if (v < 13'sd0) begin
            r = 13'sd0;
        end else if (v > 13'sd1000) begin
            r = 13'sd1000;
        end
        return r;
    endfunction

    function automatic logic [10:0] slew_step(input logic [10:0] cur, input logic signed [12:0] tgt);
        logic signed [12:0] cur_s;
        logic signed [12:0] diff;
        logic signed [12:0] step;
        logic signed [12:0] res;
        cur_s = $signed({2'b00, cur});
        step  = $signed(13'(MAX_STEP));
        diff  = tgt - cur_s;
        if (diff > step) begin
            res = cur_s + step;
        end else if (diff < -step) begin
            res = cur_s - step;
        end else begin
            res = tgt;
        end
        return res[10:0];
    endfunction

    always_comb begin
        boundary = (cnt_q == CNT_W'(PERIOD - 1));
        steer_c  = (bus.steer > 11'd1000) ? 13'sd1000 : $signed({2'b00, bus.steer});
        off      = steer_c - 13'sd500;
        tgt_l    = clamp_duty($signed(13'(BASE_SPEED)) + off);
        tgt_r    = clamp_duty($signed(13'(BASE_SPEED)) - off);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = boundary ? '0 : cnt_q + 1'b1;
        duty_l_d = duty_l_q;
        duty_r_d = duty_r_q;
        if (boundary) begin
            unique case (state_q)
                IDLE:    if (bus.enable) state_d = RUN;
                RUN:     if (!bus.enable) state_d = STOP;
                STOP: begin
                    // Re-enable takes priority over a ramp that has just finished.
                    if (bus.enable) begin
                        state_d = RUN;
                    end else if (duty_l_q == '0 && duty_r_q == '0) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            // Duties follow the target of the state being entered on this boundary.
            unique case (state_d)
                RUN: begin
                    duty_l_d = slew_step(duty_l_q, tgt_l);
                    duty_r_d = slew_step(duty_r_q, tgt_r);
                end
                STOP: begin
                    duty_l_d = slew_step(duty_l_q, 13'sd0);
                    duty_r_d = slew_step(duty_r_q, 13'sd0);
                end
                default: begin
                    duty_l_d = '0;
                    duty_r_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            duty_l_q       <= '0;
            duty_r_q       <= '0;
            pwm_l_q        <= 1'b0;
            pwm_r_q        <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            duty_l_q       <= duty_l_d;
            duty_r_q       <= duty_r_d;
            pwm_l_q        <= (int'(cnt_q) < int'(duty_l_q));
            pwm_r_q        <= (int'(cnt_q) < int'(duty_r_q));
            period_start_q <= (cnt_q == '0);
        end
    end

    assign bus.pwm_l        = pwm_l_q;
    assign bus.pwm_r        = pwm_r_q;
    assign bus.duty_l       = duty_l_q;
    assign bus.duty_r       = duty_r_q;
    assign bus.period_start = period_start_q;
    assign bus.running      = (state_q != IDLE);
endmodule

// File: tb/tb_motor_pwm.sv
// Bench for motor_pwm: directed scenarios plus random steering, every cycle compared to a period-level model.
module tb_motor_pwm;
    localparam int PERIOD = 1000;
    localparam int BASE   = 600;
    localparam int SLEW   = 50;

    logic clk = 1'b0;
    logic rst = 1'b0;

    motor_pwm_if bus ();

    motor_pwm #(
        .PERIOD    (PERIOD),
        .BASE_SPEED(BASE),
        .SLEW      (SLEW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: 0 = idle, 1 = run, 2 = stop
    int m_cnt   = 0;
    int m_state = 0;
    int m_dl    = 0;
    int m_dr    = 0;
    int n_bnd   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int tgt_of(input int s, input bit left);
        int sc, off, t;
        sc  = (s > 1000) ? 1000 : s;
        off = sc - 500;
        t   = left ? BASE + off : BASE - off;
        if (t < 0) t = 0;
        if (t > 1000) t = 1000;
        return t;
    endfunction

    function automatic int slew_to(input int cur, input int t);
`ifdef MOTOR_PWM_SLEW_EN
        if (t - cur > SLEW) return cur + SLEW;
        if (cur - t > SLEW) return cur - SLEW;
        return t;
`else
        if (cur < 0) return 0;
        return t;
`endif
    endfunction

    task automatic step();
        int e_pl, e_pr, e_ps, ns;
        if (!rst) begin
            m_cnt = 0; m_state = 0; m_dl = 0; m_dr = 0;
            e_pl = 0; e_pr = 0; e_ps = 0;
        end else begin
            e_pl = (m_cnt < m_dl) ? 1 : 0;
            e_pr = (m_cnt < m_dr) ? 1 : 0;
            e_ps = (m_cnt == 0) ? 1 : 0;
            if (m_cnt == PERIOD - 1) begin
                ns = m_state;
                if (m_state == 0) ns = bus.enable ? 1 : 0;
                else if (m_state == 1) ns = bus.enable ? 1 : 2;
                else ns = bus.enable ? 1 : ((m_dl == 0 && m_dr == 0) ? 0 : 2);
                if (ns == 1) begin
                    m_dl = slew_to(m_dl, tgt_of(int'(bus.steer), 1'b1));
                    m_dr = slew_to(m_dr, tgt_of(int'(bus.steer), 1'b0));
                end else if (ns == 2) begin
                    m_dl = slew_to(m_dl, 0);
                    m_dr = slew_to(m_dr, 0);
                end else begin
                    m_dl = 0;
                    m_dr = 0;
                end
                m_state = ns;
                m_cnt   = 0;
                n_bnd++;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        chk("pwm_l", 32'(bus.pwm_l), 32'(e_pl));
        chk("pwm_r", 32'(bus.pwm_r), 32'(e_pr));
        chk("period_start", 32'(bus.period_start), 32'(e_ps));
        chk("duty_l", 32'(bus.duty_l), 32'(m_dl));
        chk("duty_r", 32'(bus.duty_r), 32'(m_dr));
        chk("running", 32'(bus.running), (m_state != 0) ? 32'd1 : 32'd0);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_bnd(input int n);
        int target;
        target = n_bnd + n;
        while (n_bnd < target) step();
    endtask

    initial begin
        int cnt_hi_l, cnt_hi_r;
        bus.enable = 1'b0;
        bus.steer  = 11'd500;

        // Reset, idle, then reset again mid-period while running
        run_cycles(3);
        rst = 1'b1;
        run_cycles(1200);
        bus.enable = 1'b1;
        run_cycles(1500);
        rst = 1'b0;
        run_cycles(5);
        chk("reset_running", 32'(bus.running), 32'd0);
        chk("reset_duty_l", 32'(bus.duty_l), 32'd0);
        rst = 1'b1;

        // Start-up ramp
        run_bnd(12);
        chk("startup_duty_l", 32'(bus.duty_l), 32'd600);
        chk("startup_duty_r", 32'(bus.duty_r), 32'd600);

        // Turn
        bus.steer = 11'd700;
        run_bnd(4);
        chk("turn_duty_l", 32'(bus.duty_l), 32'd800);
        chk("turn_duty_r", 32'(bus.duty_r), 32'd400);

        // Mid-period steer pulse has no effect
        run_cycles(200);
        bus.steer = 11'd200;
        run_cycles(300);
        bus.steer = 11'd700;
        run_bnd(2);
        chk("pulse_duty_l", 32'(bus.duty_l), 32'd800);
        chk("pulse_duty_r", 32'(bus.duty_r), 32'd400);

        // Clamp
        bus.steer = 11'd1023;
        run_bnd(6);
        chk("clamp_duty_l", 32'(bus.duty_l), 32'd1000);
        chk("clamp_duty_r", 32'(bus.duty_r), 32'd100);
        cnt_hi_l = 0;
        cnt_hi_r = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step();
            cnt_hi_l += int'(bus.pwm_l);
            cnt_hi_r += int'(bus.pwm_r);
        end
        chk("clamp_pwm_l_high", 32'(cnt_hi_l), 32'd1000);
        chk("clamp_pwm_r_high", 32'(cnt_hi_r), 32'd100);

        // Back to straight
        bus.steer = 11'd500;
        run_bnd(10);
        chk("straight_duty_l", 32'(bus.duty_l), 32'd600);

        // Stop, re-enable mid-ramp
        bus.enable = 1'b0;
        run_bnd(6);
`ifdef MOTOR_PWM_SLEW_EN
        chk("ramp_down_duty_l", 32'(bus.duty_l), 32'd300);
        chk("ramp_down_running", 32'(bus.running), 32'd1);
`else
        chk("stop_duty_l", 32'(bus.duty_l), 32'd0);
        chk("stop_running", 32'(bus.running), 32'd0);
`endif
        bus.enable = 1'b1;
        run_bnd(8);
        chk("reramp_duty_r", 32'(bus.duty_r), 32'd600);

        // Full stop to idle
        bus.enable = 1'b0;
        run_bnd(14);
        chk("idle_running", 32'(bus.running), 32'd0);
        chk("idle_duty_l", 32'(bus.duty_l), 32'd0);
        chk("idle_pwm_r", 32'(bus.pwm_r), 32'd0);

        // Random steering and enable, with mid-period steer noise
        for (int p = 0; p < 8; p++) begin
            bus.enable = ($urandom_range(0, 3) != 0);
            bus.steer  = 11'($urandom_range(0, 2047));
            for (int c = 0; c < PERIOD; c++) begin
                if ($urandom_range(0, 199) == 0) bus.steer = 11'($urandom_range(0, 2047));
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
